// File: rtl/accumulator_controller.sv
// accumulator_controller: per-output clear/accumulate/drain/store sequencing for the column accumulator.
// ARR_SIZE is informational only; it does not affect the logic.
module accumulator_controller #(
    parameter int ARR_SIZE     = 4,
    parameter int ADDR_W       = 4,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic [CNT_W-1:0]  num_outputs,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic              acc_reset,
    output logic              store_output,
    output logic [ADDR_W-1:0] op_buffer_address,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);
    localparam int DW = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, STORE, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  tiles_q, outs_q, beat_cnt, out_cnt;
    logic [ADDR_W-1:0] addr, op_addr;
    logic [DW-1:0]     drain_cnt;
    logic              cmd_ok, err_q;

    if (ARR_SIZE < 1) begin : g_arr_check
        $error("ARR_SIZE must be positive");
    end

    assign cmd_ok            = start && num_tiles != '0 && num_outputs != '0;
    assign psum_ready        = state == ACCUM;
    assign acc_reset         = state == CLEAR;
    assign store_output      = state == STORE;
    assign busy              = state != IDLE;
    assign done              = state == DONE;
    assign cmd_err           = err_q;
    assign op_buffer_address = op_addr;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_ok ? CLEAR : IDLE;
            CLEAR:   state_n = ACCUM;
            ACCUM:   if (psum_valid && beat_cnt == tiles_q - CNT_W'(1))
                         state_n = (DRAIN_CYCLES == 0) ? STORE : DRAIN;
            DRAIN:   if (drain_cnt + DW'(1) == DW'(DRAIN_CYCLES)) state_n = STORE;
            STORE:   state_n = (out_cnt == outs_q - CNT_W'(1)) ? DONE : CLEAR;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort wins over every other transition; an in-flight STORE still shows its cycle
        if (abort && state != IDLE) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tiles_q   <= '0;
            outs_q    <= '0;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            addr      <= '0;
            op_addr   <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= state == IDLE && start && !cmd_ok;
            if (state_n == STORE) op_addr <= addr;
            case (state)
                IDLE: if (cmd_ok) begin
                    tiles_q <= num_tiles;
                    outs_q  <= num_outputs;
                    addr    <= base_addr;
                    out_cnt <= '0;
                end
                CLEAR: beat_cnt <= '0;
                ACCUM: begin
                    drain_cnt <= '0;
                    if (psum_valid) beat_cnt <= beat_cnt + CNT_W'(1);
                end
                DRAIN: drain_cnt <= drain_cnt + DW'(1);
                STORE: begin
                    addr    <= addr + ADDR_W'(1);
                    out_cnt <= out_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/accumulator_controller.md
# accumulator_controller

Sequencer for the systolic array's column accumulator. It accepts a job command (tiles per output, number of outputs, base output-buffer address). For each output it clears the accumulator, accepts the required number of partial-sum beats from the array, waits out the adder pipeline, and then issues a single-cycle store with the output-buffer address. It sits between the top-level instruction decoder and the accumulator, and it owns the accumulator's `acc_reset`, `store_output` and `op_buffer_address` inputs.

## Interface
- `ARR_SIZE`, 4: array dimension; informational, no effect on logic.
- `ADDR_W`, 4: output-buffer address width.
- `CNT_W`, 8: width of the tile and output counters.
- `DRAIN_CYCLES`, 2: adder pipeline latency in cycles. 0 is legal.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: job launch pulse. Sampled only in IDLE.
- `num_tiles`  in  CNT_W: partial-sum beats per output.
- `num_outputs`  in  CNT_W: outputs per job.
- `base_addr`  in  ADDR_W: first output-buffer address.
- `abort`  in  1: synchronous job cancel.
- `psum_valid`  in  1: array presents a partial-sum beat.
- `psum_ready`  out  1: controller accepts beats. A beat transfers when `psum_valid` and `psum_ready` are both high.
- `acc_reset`  out  1: clears the accumulator.
- `store_output`  out  1: commits the accumulator to the output buffer.
- `op_buffer_address`  out  ADDR_W: store address. Valid while `store_output` is high.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle job-complete pulse.
- `cmd_err`  out  1: one-cycle pulse on a rejected command.

## Operation
- The FSM has six states: IDLE, CLEAR, ACCUM, DRAIN, STORE, DONE.
- All outputs are Moore outputs decoded from registered state and counters. None depends combinationally on inputs.
- **IDLE**
  - `start` with `num_tiles`≠0 and `num_outputs`≠0: latch all three command fields, load addr←`base_addr`, clear out_cnt, go to CLEAR.
  - `start` with either count equal to 0: `cmd_err`=1 next cycle, stay in IDLE.
- **CLEAR**: `acc_reset`=1 for exactly one cycle. Clear beat_cnt, go to ACCUM.
- **ACCUM**: `psum_ready`=1. Each accepted beat increments beat_cnt. The beat accepted with beat_cnt==num_tiles−1 moves to DRAIN, or directly to STORE if `DRAIN_CYCLES`=0. With `psum_valid` low, stay in ACCUM indefinitely; there is no timeout.
- **DRAIN**: stay for exactly `DRAIN_CYCLES` cycles with `psum_ready`=0, then go to STORE.
- **STORE**: `store_output`=1 and `op_buffer_address`=addr for one cycle. Then addr←addr+1 modulo 2^ADDR_W (wraps silently) and out_cnt increments.
  - out_cnt was num_outputs−1: go to DONE.
  - Otherwise: go to CLEAR.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- **`start` outside IDLE**: ignored. No error, and latched fields are unchanged.
- **`abort`** (any non-IDLE state): next state is IDLE. No store and no `done`. A store already in progress in STORE still completes that cycle. `abort` takes priority over every other transition.
- **`rst`**: immediately forces IDLE and all outputs to 0, including mid-job. Counters, addr and latched fields clear to 0.

## Timing
- Reset values: `psum_ready`, `acc_reset`, `store_output`, `busy`, `done` and `cmd_err` are all 0; `op_buffer_address` is 0.
- Cycle 0 is the edge that samples `start`. Then:
  - cycle 1: CLEAR (`acc_reset`).
  - cycle 2 onward: ACCUM.
- Per-output latency with `psum_valid` held high = 1 + num_tiles + `DRAIN_CYCLES` + 1 cycles.
- Job latency = num_outputs × per-output latency + 1 (the DONE cycle).
- `op_buffer_address` holds its last value outside STORE. Only the STORE cycle is meaningful.
- `done` is never asserted in the same cycle as `store_output`.
- A new `start` is accepted at the earliest in the IDLE cycle after DONE.

## Test plan
- **Basic job**: `num_tiles`=1, `num_outputs`=1, `base_addr`=3, `DRAIN_CYCLES`=2, `psum_valid` held high → `acc_reset` at cycle 1, beat at cycle 2, `store_output` with addr 3 at cycle 5, `done` at cycle 6, `busy` low at cycle 7.
- **Multi-output with wrap**: `num_tiles`=4, `num_outputs`=3, `base_addr`=15 → stores at addresses 15, 0, 1, each preceded by one `acc_reset`, and exactly 4 beats accepted per output.
- **Stalled beats**: `psum_valid` toggled 1-0-0-1-1-0-1 with `num_tiles`=4 → DRAIN is entered only after the 4th handshake, and `psum_ready` drops during DRAIN.
- **Zero-count command**: `start` with `num_tiles`=0 → `cmd_err` pulses once, `busy` stays 0, and no `acc_reset` is issued.
- **Abort and start in ACCUM**: `abort` after 2 of 4 beats → IDLE next cycle with no `store_output` and no `done`. A `start` pulsed during ACCUM is ignored.
- **Reset mid-job**: `rst` asserted in DRAIN → all outputs 0 immediately. After `rst` is released, a fresh job starts from `base_addr`.
